// File: rtl/p2_io_pkg.sv
// Shared constants and helpers for the Project2 memory-mapped I/O block.
// Holds the I/O window addresses, the debounce default and the 7-segment decoder.
package p2_io_pkg;

  localparam int unsigned DBITS           = 32;
  localparam int unsigned DEBOUNCE_CYCLES = 100;

  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

  // Active-low segments, bit 0 = segment a.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus a per-bank debounce counter.
// A new value is accepted only after the synchronized bank differs from stable for CYCLES edges.
module io_debounce #(
  parameter int unsigned      WIDTH   = 10,
  parameter int unsigned      CYCLES  = 100,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned    CW       = $clog2(CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt;

  // Count keeps running while any bit disagrees; it is not restarted by further changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= RST_VAL;
      s2     <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller on the data-memory port: HEX/LED output registers
// and debounced SW/KEY inputs in the 0xF00000xx window.
module mmio_io_ctrl
  import p2_io_pkg::*;
#(
  parameter int unsigned DBITS_P    = DBITS,
  parameter int unsigned DEB_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic               CLOCK_50,
  input  logic               FPGA_RESET_N,
  input  logic [DBITS_P-1:0] addr,
  input  logic               wrEn,
  input  logic [DBITS_P-1:0] wrData,
  output logic [DBITS_P-1:0] rdData,
  output logic               isIo,
  input  logic [9:0]         SW,
  input  logic [3:0]         KEY,
  output logic [9:0]         LEDR,
  output logic [7:0]         LEDG,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3
);

  logic        rst;
  logic [15:0] hex_reg;
  logic [9:0]  sw_stable;
  logic [3:0]  key_stable_raw;
  logic [3:0]  key_pressed;
  logic        hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw;
  logic        unused_wr_hi;

  assign rst = FPGA_RESET_N;

  assign hit_hex  = (addr == DBITS_P'(ADDR_HEX));
  assign hit_ledr = (addr == DBITS_P'(ADDR_LEDR));
  assign hit_ledg = (addr == DBITS_P'(ADDR_LEDG));
  assign hit_key  = (addr == DBITS_P'(ADDR_KEY));
  assign hit_sw   = (addr == DBITS_P'(ADDR_SW));
  assign isIo     = hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw;

  assign unused_wr_hi = ^wrData[DBITS_P-1:16];

  io_debounce #(
    .WIDTH  (10),
    .CYCLES (DEB_CYCLES),
    .RST_VAL(10'h000)
  ) u_sw_deb (
    .clk   (CLOCK_50),
    .rst   (rst),
    .din   (SW),
    .stable(sw_stable)
  );

  // KEY is debounced in raw (active-low) form so its synchronizer resets to released.
  io_debounce #(
    .WIDTH  (4),
    .CYCLES (DEB_CYCLES),
    .RST_VAL(4'hF)
  ) u_key_deb (
    .clk   (CLOCK_50),
    .rst   (rst),
    .din   (KEY),
    .stable(key_stable_raw)
  );

  assign key_pressed = ~key_stable_raw;

  // Output registers; segments are decoded at the store edge so pins are registered.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      hex_reg <= '0;
      LEDR    <= '0;
      LEDG    <= '0;
      HEX0    <= hex7seg(4'h0);
      HEX1    <= hex7seg(4'h0);
      HEX2    <= hex7seg(4'h0);
      HEX3    <= hex7seg(4'h0);
    end else if (wrEn) begin
      if (hit_hex) begin
        hex_reg <= wrData[15:0];
        HEX0    <= hex7seg(wrData[3:0]);
        HEX1    <= hex7seg(wrData[7:4]);
        HEX2    <= hex7seg(wrData[11:8]);
        HEX3    <= hex7seg(wrData[15:12]);
      end
      if (hit_ledr) LEDR <= wrData[9:0];
      if (hit_ledg) LEDG <= wrData[7:0];
    end
  end

  always_comb begin
    rdData = '0;
    if (hit_hex)  rdData = DBITS_P'(hex_reg);
    if (hit_ledr) rdData = DBITS_P'(LEDR);
    if (hit_ledg) rdData = DBITS_P'(LEDG);
    if (hit_key)  rdData = DBITS_P'(key_pressed);
    if (hit_sw)   rdData = DBITS_P'(sw_stable);
  end

endmodule
